// File: rtl/apb_fifo_pkg.sv
// Shared constants, register map and APB state type for the APB-to-FIFO bridge.
// Used by the write front-end and reusable by the read side.
package apb_fifo_pkg;

  localparam int FIFO_AW    = 8;
  localparam int FIFO_DW    = 9;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam int APB_AW     = 4;

  localparam int DATA_OFS   = 'h0;
  localparam int STATUS_OFS = 'h4;
  localparam int CTRL_OFS   = 'h8;

  localparam int STATUS_CNT_LSB   = 0;
  localparam int STATUS_EMPTY_BIT = 9;
  localparam int STATUS_FULL_BIT  = 10;
  localparam int CTRL_FLUSH_BIT   = 0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS
  } apb_state_t;

  function automatic logic [31:0] status_word(input logic [FIFO_AW:0] cnt,
                                              input logic              emp,
                                              input logic              ful);
    logic [31:0] w;
    w = '0;
    w[STATUS_CNT_LSB +: FIFO_AW+1] = cnt;
    w[STATUS_EMPTY_BIT]            = emp;
    w[STATUS_FULL_BIT]             = ful;
    return w;
  endfunction

endpackage

// File: rtl/fifo_ptr_status.sv
// Occupancy, full and empty from a write/read pointer pair carrying an extra wrap bit.
// Purely combinational so either side of the FIFO can instantiate it.
module fifo_ptr_status #(
  parameter int AW = 8
) (
  input  logic [AW:0] i_wr_ptr,
  input  logic [AW:0] i_rd_ptr,
  output logic [AW:0] o_count,
  output logic        o_full,
  output logic        o_empty
);

  // Modular subtraction over AW+1 bits yields 0..2**AW directly.
  assign o_count = i_wr_ptr - i_rd_ptr;
  assign o_full  = (i_wr_ptr[AW-1:0] == i_rd_ptr[AW-1:0]) && (i_wr_ptr[AW] != i_rd_ptr[AW]);
  assign o_empty = (i_wr_ptr == i_rd_ptr);

endmodule

// File: rtl/apb_fifo_wr_ctrl.sv
// APB slave write front-end: turns DATA writes into single-cycle pushes on memory port 1.
// Define APB_WAIT_ON_FULL_EN to stall a full-FIFO DATA write instead of erroring it.
//
// state  | meaning
// IDLE   | previous cycle had no transfer
// SETUP  | setup phase sampled; bus now in first access cycle
// ACCESS | access phase sampled; either completed or held waiting
module apb_fifo_wr_ctrl
  import apb_fifo_pkg::*;
#(
  parameter int AW  = FIFO_AW,
  parameter int DW  = FIFO_DW,
  parameter int PAW = APB_AW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           PSEL,
  input  logic           PENABLE,
  input  logic           PWRITE,
  input  logic [PAW-1:0] PADDR,
  input  logic [31:0]    PWDATA,
  output logic [31:0]    PRDATA,
  output logic           PREADY,
  output logic           PSLVERR,
  input  logic [AW:0]    rd_ptr_i,
  output logic [AW-1:0]  A1,
  output logic [DW-1:0]  WD1,
  output logic           WE1,
  output logic [AW:0]    wr_ptr_o,
  output logic           full,
  output logic           empty
);

  apb_state_t      r_state;
  apb_state_t      w_state_nxt;
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_wr_ptr_o;
  logic [AW-1:0]   r_a1;
  logic [DW-1:0]   r_wd1;
  logic            r_we1;
  logic            r_pready;
  logic            r_pslverr;
  logic [31:0]     r_prdata;

  logic            w_setup;
  logic            w_access;
  logic            w_xfer;
  logic            w_sel_data;
  logic            w_sel_status;
  logic            w_sel_ctrl;
  logic            w_dec_err;
  logic            w_full_err;
  logic            w_hold;
  logic            w_release;
  logic            w_push;
  logic            w_flush;
  logic            w_rd_xfer;
  logic [31:0]     w_rd_val;
  logic [AW:0]     w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_unused_pwdata;

  fifo_ptr_status #(.AW(AW)) u_status (
    .i_wr_ptr (r_wr_ptr),
    .i_rd_ptr (rd_ptr_i),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign w_setup      = PSEL & ~PENABLE;
  assign w_access     = PSEL & PENABLE;
  assign w_xfer       = w_access & r_pready;
  assign w_sel_data   = (PADDR == PAW'(DATA_OFS));
  assign w_sel_status = (PADDR == PAW'(STATUS_OFS));
  assign w_sel_ctrl   = (PADDR == PAW'(CTRL_OFS));

`ifdef APB_WAIT_ON_FULL_EN
  assign w_hold     = PWRITE & w_sel_data & w_full;
  assign w_full_err = 1'b0;
  assign w_release  = ~w_full;
`else
  assign w_hold     = 1'b0;
  assign w_full_err = PWRITE & w_sel_data & w_full;
  assign w_release  = 1'b1;
`endif

  assign w_dec_err = ~(w_sel_data | w_sel_status | w_sel_ctrl)
                   | (PWRITE & w_sel_status)
                   | w_full_err;

  // Error flag was latched at setup, so a rejected DATA write never reaches the memory.
  assign w_push    = w_xfer & PWRITE & w_sel_data & ~r_pslverr;
  assign w_flush   = w_xfer & PWRITE & w_sel_ctrl & PWDATA[CTRL_FLUSH_BIT];
  assign w_rd_xfer = w_xfer & ~PWRITE;
  assign w_rd_val  = w_sel_status ? status_word(w_count, w_empty, w_full) : 32'h0;

  assign w_unused_pwdata = ^PWDATA[31:DW];

  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    if (w_setup) w_state_nxt = SETUP;
      SETUP:   if (w_access) w_state_nxt = ACCESS;
      ACCESS: begin
        if (w_setup)       w_state_nxt = SETUP;
        else if (w_access) w_state_nxt = ACCESS;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_wr_ptr_o <= '0;
      r_a1       <= '0;
      r_wd1      <= '0;
      r_we1      <= 1'b0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_prdata   <= '0;
    end else begin
      r_state <= w_state_nxt;

      // PREADY is presented one cycle after the decision that produced it.
      if (w_state_nxt == SETUP)
        r_pready <= ~w_hold;
      else if ((w_state_nxt == ACCESS) && !w_xfer)
        r_pready <= w_release;
      else
        r_pready <= 1'b0;

      r_pslverr <= (w_state_nxt == SETUP) ? w_dec_err : 1'b0;

      r_we1 <= w_push;
      if (w_push) begin
        r_a1  <= r_wr_ptr[AW-1:0];
        r_wd1 <= PWDATA[DW-1:0];
      end

      if (w_flush)
        r_wr_ptr <= rd_ptr_i;
      else if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;

      // Published pointer follows only once the memory has taken the data.
      if (w_flush)
        r_wr_ptr_o <= rd_ptr_i;
      else if (r_we1)
        r_wr_ptr_o <= r_wr_ptr;

      if (w_rd_xfer)
        r_prdata <= w_rd_val;
    end
  end

  assign PRDATA   = w_rd_xfer ? w_rd_val : r_prdata;
  assign PREADY   = r_pready;
  assign PSLVERR  = r_pslverr;
  assign A1       = r_a1;
  assign WD1      = r_wd1;
  assign WE1      = r_we1;
  assign wr_ptr_o = r_wr_ptr_o;
  assign full     = w_full;
  assign empty    = w_empty;

endmodule

// File: tb/tb_apb_fifo_wr_ctrl.sv
// Directed bench for apb_fifo_wr_ctrl; expectations are hand-computed constants.
// Build with APB_WAIT_ON_FULL_EN to exercise the stall-on-full variant.
module tb_apb_fifo_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [8:0]  rd_ptr_i;
  logic [7:0]  A1;
  logic [8:0]  WD1;
  logic        WE1;
  logic [8:0]  wr_ptr_o;
  logic        full;
  logic        empty;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;

  apb_fifo_wr_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .rd_ptr_i (rd_ptr_i),
    .A1       (A1),
    .WD1      (WD1),
    .WE1      (WE1),
    .wr_ptr_o (wr_ptr_o),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (WE1) we_cnt <= we_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failed=%0d", n_fail);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One APB transfer; adv_after>0 bumps rd_ptr_i when that many wait cycles are seen.
  task automatic apb(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                     input int adv_after, output logic slverr, output logic [31:0] rdata,
                     output int waits);
    bit done;
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    waits = 0; slverr = 1'b0; rdata = '0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (PREADY) begin
        slverr = PSLVERR;
        rdata  = PRDATA;
        done   = 1'b1;
      end else begin
        waits++;
        if (waits == adv_after) rd_ptr_i = rd_ptr_i + 1'b1;
        if (waits > 40) begin
          check("pready_timeout", PREADY, 1);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    logic        err;
    logic [31:0] rd;
    int          w;
    int          base;
    int          errs;

    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; rd_ptr_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we1", WE1, 0);
    check("rst_a1", A1, 0);
    check("rst_wd1", WD1, 0);
    check("rst_wr_ptr_o", wr_ptr_o, 0);
    check("rst_pready", PREADY, 0);
    check("rst_pslverr", PSLVERR, 0);
    check("rst_prdata", PRDATA, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    @(posedge clk); #1 rst = 1'b0;

    // First push and its commit latency
    base = we_cnt;
    apb(1'b1, 4'h0, 32'h1A5, -1, err, rd, w);
    check("push1_err", err, 0);
    check("push1_waits", w, 0);
    check("push1_we1", WE1, 1);
    check("push1_a1", A1, 8'h00);
    check("push1_wd1", WD1, 9'h1A5);
    check("push1_ptr_o_early", wr_ptr_o, 0);
    @(posedge clk); #1;
    check("push1_we1_off", WE1, 0);
    check("push1_ptr_o", wr_ptr_o, 9'h001);
    check("push1_we_pulses", we_cnt - base, 1);
    apb(1'b0, 4'h4, 32'h0, -1, err, rd, w);
    check("stat1_err", err, 0);
    check("stat1", rd, 32'h001);

    // Fill to 256 from an empty FIFO
    apb(1'b1, 4'h8, 32'h1, -1, err, rd, w);
    check("flush0_empty", empty, 1);
    base = we_cnt; errs = 0;
    for (int i = 0; i < 256; i++) begin
      apb(1'b1, 4'h0, i, -1, err, rd, w);
      if (err) errs++;
    end
    @(posedge clk); #1;
    check("fill_errs", errs, 0);
    check("fill_we_pulses", we_cnt - base, 256);
    check("fill_last_a1", A1, 8'hFF);
    check("fill_ptr_o", wr_ptr_o, 9'h100);
    check("fill_full", full, 1);
    apb(1'b0, 4'h4, 32'h0, -1, err, rd, w);
    check("stat_full", rd, 32'h500);

`ifdef APB_WAIT_ON_FULL_EN
    base = we_cnt;
    apb(1'b1, 4'h0, 32'h055, 5, err, rd, w);
    check("wait_cycles", w, 5);
    check("wait_err", err, 0);
    check("wait_we1", WE1, 1);
    check("wait_wd1", WD1, 9'h055);
    check("wait_a1", A1, 8'h00);
    @(posedge clk); #1;
    check("wait_ptr_o", wr_ptr_o, 9'h101);
    check("wait_we_pulses", we_cnt - base, 1);
`else
    base = we_cnt;
    apb(1'b1, 4'h0, 32'h055, -1, err, rd, w);
    check("full_push_err", err, 1);
    check("full_push_waits", w, 0);
    @(posedge clk); #1;
    check("full_push_we_pulses", we_cnt - base, 0);
    check("full_push_ptr_o", wr_ptr_o, 9'h100);
`endif

    // Pointer and address wrap
    rd_ptr_i = 9'h1FF;
    apb(1'b1, 4'h8, 32'h1, -1, err, rd, w);
    check("wrap_flush_ptr_o", wr_ptr_o, 9'h1FF);
    rd_ptr_i = 9'h100;
    apb(1'b1, 4'h0, 32'h0AA, -1, err, rd, w);
    check("wrap_push1_err", err, 0);
    check("wrap_push1_a1", A1, 8'hFF);
    check("wrap_full", full, 1);
    @(posedge clk); #1;
    rd_ptr_i = 9'h000;
    apb(1'b1, 4'h0, 32'h0BB, -1, err, rd, w);
    check("wrap_push2_err", err, 0);
    check("wrap_push2_a1", A1, 8'h00);
    check("wrap_push2_wd1", WD1, 9'h0BB);
    @(posedge clk); #1;
    check("wrap_ptr_o", wr_ptr_o, 9'h001);
    apb(1'b0, 4'h4, 32'h0, -1, err, rd, w);
    check("wrap_stat", rd, 32'h001);

    // Flush to an arbitrary read pointer
    rd_ptr_i = 9'h037;
    base = we_cnt;
    apb(1'b1, 4'h8, 32'h1, -1, err, rd, w);
    check("flush_err", err, 0);
    check("flush_ptr_o", wr_ptr_o, 9'h037);
    check("flush_empty", empty, 1);
    check("flush_we1", WE1, 0);
    @(posedge clk); #1;
    check("flush_we_pulses", we_cnt - base, 0);
    apb(1'b0, 4'h4, 32'h0, -1, err, rd, w);
    check("flush_stat", rd, 32'h200);
    @(negedge clk);
    check("prdata_hold", PRDATA, 32'h200);

    // Decode errors leave state alone
    base = we_cnt;
    apb(1'b1, 4'hC, 32'h1FF, -1, err, rd, w);
    check("bad_addr_err", err, 1);
    check("bad_addr_waits", w, 0);
    apb(1'b1, 4'h4, 32'h1, -1, err, rd, w);
    check("stat_wr_err", err, 1);
    apb(1'b0, 4'hC, 32'h0, -1, err, rd, w);
    check("bad_rd_err", err, 1);
    check("bad_rd_data", rd, 0);
    apb(1'b0, 4'h0, 32'h0, -1, err, rd, w);
    check("data_rd_err", err, 0);
    check("data_rd_val", rd, 0);
    @(posedge clk); #1;
    check("err_ptr_o", wr_ptr_o, 9'h037);
    check("err_empty", empty, 1);
    check("err_we_pulses", we_cnt - base, 0);

    // Reset in the access phase aborts the push
    rd_ptr_i = 9'h000;
    base = we_cnt;
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'h0; PWDATA = 32'h111;
    @(posedge clk); #1;
    PENABLE = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    check("abort_pready", PREADY, 0);
    check("abort_we1", WE1, 0);
    check("abort_ptr_o", wr_ptr_o, 0);
    check("abort_empty", empty, 1);
    check("abort_we_pulses", we_cnt - base, 0);
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
